// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between source A
// (ALU results) and source B (load / multicycle unit). Writes to register 0
// are acknowledged and dropped. Write-port outputs are registered.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_last_b,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic a_live;
  logic a_null;
  logic b_live;
  logic b_null;
  logic grant_a;
  logic grant_b;

  // Classify requests and pick the winner; a null request never competes.
  always_comb begin
    a_live    = 1'b0;
    a_null    = 1'b0;
    b_live    = 1'b0;
    b_null    = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;

    a_live  = i_a_valid && (i_a_addr != '0);
    a_null  = i_a_valid && (i_a_addr == '0);
    b_live  = i_b_valid && (i_b_addr != '0);
    b_null  = i_b_valid && (i_b_addr == '0);
    // On a tie the source not granted most recently wins.
    grant_a = a_live && (!b_live || o_last_b);
    grant_b = b_live && (!a_live || !o_last_b);

    if (!i_rst) begin
      o_a_ready = a_null || grant_a;
      o_b_ready = b_null || grant_b;
    end
  end

  // Write port, round-robin pointer and saturating conflict counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_we           <= 1'b0;
      o_waddr        <= '0;
      o_wdata        <= '0;
      o_last_b       <= 1'b1;
      o_conflict_cnt <= '0;
    end else begin
      if (grant_a) begin
        o_we     <= 1'b1;
        o_waddr  <= i_a_addr;
        o_wdata  <= i_a_data;
        o_last_b <= 1'b0;
      end else if (grant_b) begin
        o_we     <= 1'b1;
        o_waddr  <= i_b_addr;
        o_wdata  <= i_b_data;
        o_last_b <= 1'b1;
      end else begin
        o_we <= 1'b0;
      end

      if (a_live && b_live && (o_conflict_cnt != CNT_MAX)) begin
        o_conflict_cnt <= o_conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes
// tagged with the cycle they must appear in; a monitor pops and compares.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, we, last_b;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [15:0]   cnt;

  logic          s_a_ready, s_b_ready, s_we, s_last_b;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic [1:0]    s_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .o_last_b(last_b), .o_conflict_cnt(cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(s_a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(s_b_ready),
    .o_we(s_we), .o_waddr(s_waddr), .o_wdata(s_wdata),
    .o_last_b(s_last_b), .o_conflict_cnt(s_cnt)
  );

  typedef struct {
    int          due;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] rf [0:31];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cycle counter and a register-file model fed by the DUT write port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we === 1'b1) rf[waddr] <= wdata;
  end

  // Monitor: every cycle either the due write is present or o_we is low.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("wr_we", 64'(we), 64'd1);
        chk("wr_addr", 64'(waddr), 64'(e.a));
        chk("wr_data", 64'(wdata), 64'(e.d));
      end else begin
        chk("idle_we", 64'(we), 64'd0);
      end
      chk("sat_we_match", 64'(s_we), 64'(we));
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic r,
                      input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic ear, input logic ebr,
                      input logic ewr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    exp_t e;
    rst = r;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    if (ewr) begin
      e.due = cyc + 1; e.a = wa; e.d = wd;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("a_ready", 64'(a_ready), 64'(ear));
    chk("b_ready", 64'(b_ready), 64'(ebr));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset with requests present: no readys, reset values.
    step(1'b1, 1'b1, 5'd5, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_last_b", 64'(last_b), 64'd1);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);

    // A alone.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("a_alone_last_b", 64'(last_b), 64'd0);
    idle(1'b0);
    chk("a_alone_we_after", 64'(we), 64'd0);
    chk("a_alone_waddr_hold", 64'(waddr), 64'd5);

    // Both live for 4 cycles after reset: A, B, A, B.
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd7, 32'hB7,
           (k % 2) == 0, (k % 2) == 1, 1'b1,
           ((k % 2) == 0) ? 5'd3 : 5'd7, ((k % 2) == 0) ? 32'hA3 : 32'hB7);
      chk("rr_cnt", 64'(cnt), 64'(k + 1));
      chk("rr_last_b", 64'(last_b), 64'((k % 2) == 1));
      chk("rr_sat_cnt", 64'(s_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    idle(1'b0);
    chk("rr_cnt_idle", 64'(cnt), 64'd4);

    // Null A request with live B: both ready, only reg 9 written.
    step(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99);
    chk("null_last_b", 64'(last_b), 64'd1);
    chk("null_cnt", 64'(cnt), 64'd4);
    idle(1'b0);

    // Same destination from reset: 0x11 then 0x22.
    idle(1'b1);
    step(1'b0, 1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0, 1'b1, 5'd4, 32'h11);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b1, 5'd4, 32'h22);
    idle(1'b0);
    idle(1'b0);
    chk("same_dest_rf4", 64'(rf[4]), 64'h22);
    chk("same_dest_cnt", 64'(cnt), 64'd1);

    // Saturation of the 2-bit counter over 6 conflict cycles.
    idle(1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'd2, 32'h200 + 32'(k),
           (k % 2) == 0, (k % 2) == 1, 1'b1,
           ((k % 2) == 0) ? 5'd1 : 5'd2, ((k % 2) == 0) ? 32'h100 + 32'(k) : 32'h200 + 32'(k));
      chk("sat_cnt", 64'(s_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
      chk("wide_cnt", 64'(cnt), 64'(k + 1));
    end
    idle(1'b0);
    chk("sat_hold1", 64'(s_cnt), 64'd3);
    idle(1'b0);
    chk("sat_hold2", 64'(s_cnt), 64'd3);

    // Reset in the cycle after a grant: write visible then cleared.
    step(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h66);
    chk("mid_last_b_pre", 64'(last_b), 64'd0);
    step(1'b1, 1'b1, 5'd6, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("mid_we", 64'(we), 64'd0);
    chk("mid_last_b", 64'(last_b), 64'd1);
    chk("mid_cnt", 64'(cnt), 64'd0);
    // Arbitration restarts with A preferred.
    step(1'b0, 1'b1, 5'd2, 32'h2A, 1'b1, 5'd8, 32'h8B, 1'b1, 1'b0, 1'b1, 5'd2, 32'h2A);
    idle(1'b0);
    idle(1'b0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
